// File: rtl/bit_unstuffer_if.sv
`default_nettype none
// ============================================================================
// Module      : bit_unstuffer_if
// Description : Signal bundle between the NRZI decoder side and the bit
//               decoder side of the USB receive-path bit unstuffer.
//               master : drives the serial stream and framing, observes
//                        the unstuffed result (upstream / bench view).
//               slave  : the unstuffer itself.
// Signals     : s_in, start_unstuffer, end_unstuffer, abort (to unstuffer)
//               s_out, start_decode, end_decode, bitUnstuff_wait (from it)
// Revision    : 1.0 - initial release
// ============================================================================
interface bit_unstuffer_if;
  logic s_in;
  logic start_unstuffer;
  logic end_unstuffer;
  logic abort;
  logic s_out;
  logic start_decode;
  logic end_decode;
  logic bitUnstuff_wait;

  modport master (
    output s_in, start_unstuffer, end_unstuffer, abort,
    input  s_out, start_decode, end_decode, bitUnstuff_wait
  );

  modport slave (
    input  s_in, start_unstuffer, end_unstuffer, abort,
    output s_out, start_decode, end_decode, bitUnstuff_wait
  );
endinterface
`default_nettype wire

// File: rtl/bit_unstuffer.sv
`default_nettype none
// ============================================================================
// Module      : bit_unstuffer
// Description : Removes USB stuffed bits from the decoded serial stream.
//               After six consecutive forwarded 1s the next bit is dropped
//               and its output slot is flagged with bitUnstuff_wait.
//               Every input bit maps to exactly one output slot, one cycle
//               later; framing strobes follow with the same latency.
// Ports       : clk    - system clock, rising edge
//               rst_n  - synchronous active-low reset
//               bus    - bit_unstuffer_if.slave (serial in/out + framing)
// Revision    : 1.0 - initial release
// ============================================================================
module bit_unstuffer (
  input  logic           clk,
  input  logic           rst_n,
  bit_unstuffer_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [2:0] STUFF_RUN = 3'd6;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       s_out_q, s_out_d;
  logic       start_q, start_d;
  logic       end_q, end_d;
  logic       wait_q, wait_d;

  logic       take_bit;
  logic [2:0] run_base;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      s_out_q <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_out_q <= s_out_d;
      start_q <= start_d;
      end_q   <= end_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_out_d = 1'b0;
    start_d = 1'b0;
    end_d   = 1'b0;
    wait_d  = 1'b0;

    // The start cycle's bit is processed too, so the run length seen by
    // that bit must be zero rather than whatever the counter holds.
    take_bit = (state_q == ACTIVE) || bus.start_unstuffer;
    run_base = (state_q == ACTIVE) ? cnt_q : 3'd0;

    if (bus.abort) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else if (take_bit) begin
      start_d = (state_q == IDLE);
      end_d   = bus.end_unstuffer;
      state_d = bus.end_unstuffer ? IDLE : ACTIVE;

      if (run_base == STUFF_RUN) begin
        // Stuffed slot: dropped whatever its value; integrity is left to
        // the CRC/PID checks further downstream.
        wait_d = 1'b1;
        cnt_d  = 3'd0;
      end else begin
        s_out_d = bus.s_in;
        cnt_d   = bus.s_in ? (run_base + 3'd1) : 3'd0;
      end

      if (bus.end_unstuffer) begin
        cnt_d = 3'd0;
      end
    end
  end

  assign bus.s_out           = s_out_q;
  assign bus.start_decode    = start_q;
  assign bus.end_decode      = end_q;
  assign bus.bitUnstuff_wait = wait_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_unstuffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_unstuffer
// Description : Self-checking bench for bit_unstuffer. A directed vector
//               table, a few hand-written multi-cycle sequences and a long
//               randomized run compared against a packet-history model.
//               Output slots are compared as {s_out, start_decode,
//               end_decode, bitUnstuff_wait}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_unstuffer;

  logic clk;
  logic rst_n;

  bit_unstuffer_if bus ();

  bit_unstuffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       s;
    logic       st;
    logic       en;
    logic       ab;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];

  // Reference model: the history of the current packet's slots.
  // 0 = forwarded 0, 1 = forwarded 1, 2 = dropped stuffed slot.
  bit m_in_pkt = 1'b0;
  int m_hist[$];

  task automatic add(input logic s, st, en, ab, input logic [3:0] exp,
                     input string name);
    vec_t v;
    v.s = s; v.st = st; v.en = en; v.ab = ab; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] exp,
                       output logic [3:0] got);
    got = {bus.s_out, bus.start_decode, bus.end_decode, bus.bitUnstuff_wait};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got {s,st,en,w}=%b expected %b", name, got, exp);
    end
  endtask

  task automatic apply(input logic s, st, en, ab, input logic [3:0] exp,
                       input string name, output logic [3:0] got);
    bus.s_in            = s;
    bus.start_unstuffer = st;
    bus.end_unstuffer   = en;
    bus.abort           = ab;
    @(posedge clk);
    #1;
    check(name, exp, got);
  endtask

  // A slot is stuffed exactly when the six slots before it in the same
  // packet were all forwarded 1s.
  task automatic model_step(input logic s, st, en, ab,
                            output logic [3:0] exp);
    bit first;
    bit stuffed;
    exp = 4'b0000;
    if (ab) begin
      m_in_pkt = 1'b0;
      m_hist.delete();
    end else if (m_in_pkt || st) begin
      first = !m_in_pkt;
      if (first) m_hist.delete();
      stuffed = (m_hist.size() >= 6);
      for (int k = 1; k <= 6 && stuffed; k++)
        if (m_hist[m_hist.size() - k] != 1) stuffed = 1'b0;
      m_hist.push_back(stuffed ? 2 : int'(s));
      if (m_hist.size() > 6) void'(m_hist.pop_front());
      m_in_pkt = !en;
      exp = {(stuffed ? 1'b0 : s), first, en, stuffed};
    end
  endtask

  task automatic mstep(input logic s, st, en, ab, input string name,
                       output logic [3:0] got);
    logic [3:0] exp;
    model_step(s, st, en, ab, exp);
    apply(s, st, en, ab, exp, name, got);
  endtask

  task automatic reset_step(input string name);
    logic [3:0] got;
    rst_n = 1'b0;
    bus.s_in            = 1'($urandom);
    bus.start_unstuffer = 1'($urandom);
    bus.end_unstuffer   = 1'($urandom);
    bus.abort           = 1'b0;
    @(posedge clk);
    #1;
    check(name, 4'b0000, got);
    m_in_pkt = 1'b0;
    m_hist.delete();
    rst_n = 1'b1;
  endtask

  // Sends a whole packet through the model (start on first, end on last).
  task automatic send_pkt(input logic bits[$], input string name);
    logic [3:0] got;
    for (int i = 0; i < bits.size(); i++)
      mstep(bits[i], i == 0, i == bits.size() - 1, 1'b0, name, got);
  endtask

  initial begin
    logic [3:0] got;
    logic       pkt[$];
    int         wait_at[$];
    int         ones;
    logic [63:0] payload;
    logic s, st, en, ab;

    // ---------------- directed table ----------------
    // ACK PID, no stuffing
    add(0,1,0,0,4'b0100,"ack0"); add(1,0,0,0,4'b1000,"ack1");
    add(0,0,0,0,4'b0000,"ack2"); add(0,0,0,0,4'b0000,"ack3");
    add(1,0,0,0,4'b1000,"ack4"); add(0,0,0,0,4'b0000,"ack5");
    add(1,0,0,0,4'b1000,"ack6"); add(1,0,1,0,4'b1010,"ack7");
    add(1,0,0,0,4'b0000,"idle_garbage");
    // single stuffed bit
    add(1,1,0,0,4'b1100,"stf0");
    for (int i = 1; i < 6; i++) add(1,0,0,0,4'b1000,"stf_run");
    add(0,0,0,0,4'b0001,"stf_drop"); add(1,0,1,0,4'b1010,"stf_end");
    // stuffed bit is the last bit
    add(1,1,0,0,4'b1100,"last0");
    for (int i = 1; i < 6; i++) add(1,0,0,0,4'b1000,"last_run");
    add(0,0,1,0,4'b0011,"last_stuffed_end");
    // abort after 4 bits, then end while idle is ignored
    add(1,1,0,0,4'b1100,"ab0"); add(1,0,0,0,4'b1000,"ab1");
    add(1,0,0,0,4'b1000,"ab2"); add(1,0,0,0,4'b1000,"ab3");
    add(1,0,0,1,4'b0000,"abort_flush"); add(1,0,1,0,4'b0000,"end_in_idle");
    // fresh packet after abort: counter must start at 0; stuffed 1 dropped
    add(1,1,0,0,4'b1100,"post_ab0");
    for (int i = 1; i < 6; i++) add(1,0,0,0,4'b1000,"post_ab_run");
    add(1,0,0,0,4'b0001,"post_ab_drop1"); add(0,0,1,0,4'b0010,"post_ab_end");
    // start while active is ignored
    add(0,1,0,0,4'b0100,"sa0"); add(1,1,0,0,4'b1000,"start_in_active");
    add(1,0,1,0,4'b1010,"sa_end");
    // single-bit packet and abort priority
    add(1,1,1,0,4'b1110,"single_bit");
    add(1,1,1,1,4'b0000,"abort_beats_start");
    // counter does not carry between back-to-back packets
    add(1,1,0,0,4'b1100,"cA0"); add(1,0,0,0,4'b1000,"cA1");
    add(1,0,1,0,4'b1010,"cA2");
    add(1,1,0,0,4'b1100,"cB0"); add(1,0,0,0,4'b1000,"cB1");
    add(1,0,0,0,4'b1000,"cB2"); add(1,0,1,0,4'b1010,"cB3_no_carry");
    // abort beats end
    add(0,1,0,0,4'b0100,"ae0"); add(1,0,1,1,4'b0000,"abort_beats_end");

    rst_n = 1'b0;
    bus.s_in = 1'b0; bus.start_unstuffer = 1'b0;
    bus.end_unstuffer = 1'b0; bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 4'b0000, got);
    rst_n = 1'b1;

    foreach (tbl[i])
      apply(tbl[i].s, tbl[i].st, tbl[i].en, tbl[i].ab, tbl[i].exp,
            tbl[i].name, got);

    // ---------------- hand-written sequences ----------------
    // Twelve 1s with two stuffs: pulses must be seven slots apart.
    pkt = {1,1,1,1,1,1,0,1,1,1,1,1,1,0};
    ones = 0;
    foreach (pkt[i]) begin
      mstep(pkt[i], i == 0, i == pkt.size() - 1, 1'b0, "twelve", got);
      if (got[0]) wait_at.push_back(i);
      if (!got[0] && got[3]) ones++;
    end
    total++;
    if (wait_at.size() != 2 || (wait_at[1] - wait_at[0]) != 7) begin
      bad++;
      $display("FAIL twelve_wait_spacing: got %0d pulses, expected 2 at distance 7",
               wait_at.size());
    end
    total++;
    if (ones != 12) begin
      bad++;
      $display("FAIL twelve_valid_ones: got %0d expected 12", ones);
    end

    // 0-broken run strips nothing
    send_pkt({1,1,1,1,1,0,1,1,1,1,1}, "broken_run");

    // reset mid-packet, then a clean packet that needs exactly one stuff
    send_pkt({1,1,1}, "pre_rst");
    mstep(1, 1, 0, 0, "rst_pkt0", got);
    mstep(1, 0, 0, 0, "rst_pkt1", got);
    mstep(1, 0, 0, 0, "rst_pkt2", got);
    reset_step("reset_mid_packet");
    send_pkt({1,1,1,1,1,1,0,1}, "after_reset");

    // garbage while idle
    for (int i = 0; i < 20; i++)
      mstep(1'($urandom), 1'b0, 1'($urandom), 1'b0, "idle_noise", got);

    // 8-bit PID then 64-bit payload back-to-back
    send_pkt({1,1,0,0,0,0,1,1}, "pid");
    payload = {32'hFFFF_FFFF, $urandom} | 64'h0000_0000_FC3F_0000;
    pkt.delete();
    for (int i = 0; i < 64; i++) pkt.push_back(payload[i]);
    send_pkt(pkt, "payload64");

    // ---------------- randomized run ----------------
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset_step("rand_reset");
      end else begin
        if (!m_in_pkt) begin
          st = ($urandom_range(0, 7) == 0);
          en = st ? ($urandom_range(0, 15) == 0) : 1'($urandom);
          s  = 1'($urandom);
        end else begin
          s  = ($urandom_range(0, 99) < 85);
          en = ($urandom_range(0, 23) == 0);
          st = ($urandom_range(0, 31) == 0);
        end
        ab = ($urandom_range(0, 149) == 0);
        mstep(s, st, en, ab, $sformatf("rand_c%0d", c), got);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
